// File: rtl/tlb_lru_state_pkg.sv
// Shared sizes, types and FSM encoding for the TLB LRU counter store.
// Way 0 of a row sits in the least significant counter slot.
package tlb_lru_state_pkg;

  localparam int NUM_SETS = 16;
  localparam int SET_BITS = 4;
  localparam int NUM_WAYS = 4;
  localparam int LRU_BITS = 4;

  typedef logic [LRU_BITS-1:0] cnt_t;
  typedef logic [1:0]          way_t;
  typedef logic [SET_BITS-1:0] set_t;
  typedef cnt_t [NUM_WAYS-1:0] row_t;

  localparam cnt_t MAXC = '1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tlb_lru_state.sv
// Per-set LRU recency counters: clears all rows after reset/flush, then applies
// hit touches and victim fills using min/max information returned by tlb_lru.
module tlb_lru_state
  import tlb_lru_state_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  output logic                         init_busy,
  input  logic                         touch_valid,
  input  logic [SET_BITS-1:0]          touch_set,
  input  logic [1:0]                   touch_way,
  input  logic                         fill_valid,
  input  logic [SET_BITS-1:0]          fill_set,
  output logic                         fill_ready,
  output logic                         fill_done,
  output logic [1:0]                   fill_way,
  output logic [NUM_WAYS*LRU_BITS-1:0] lru_count_o,
  input  logic [1:0]                   replace_way_i,
  input  logic [LRU_BITS-1:0]          max_lru_value_i
);

  // Promote way w to most recent without ever wrapping a counter: bump past the
  // max while headroom remains, otherwise rebase on the minimum or halve all.
  function automatic row_t touch_update(input row_t c, input way_t w,
                                        input cnt_t mx, input way_t rw);
    row_t        r;
    cnt_t        mn;
    int unsigned n_max;
    r     = c;
    mn    = c[rw];
    n_max = 0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (c[i] == mx) n_max++;
    end
    if (c[w] == mx && n_max == 1) begin
      r = c;
    end else if (mx != MAXC) begin
      r[w] = mx + cnt_t'(1);
    end else if (mn != '0) begin
      for (int i = 0; i < NUM_WAYS; i++) r[i] = c[i] - mn;
      r[w] = MAXC - mn + cnt_t'(1);
    end else begin
      for (int i = 0; i < NUM_WAYS; i++) r[i] = c[i] >> 1;
      r[w] = (MAXC >> 1) + cnt_t'(1);
    end
    return r;
  endfunction

  state_t state, state_next;
  set_t   init_ptr, init_ptr_next;
  row_t   rows [NUM_SETS];
  set_t   sel_set;
  row_t   sel_row;
  way_t   upd_way;
  logic   fill_accept;
  logic   row_we;
  set_t   row_waddr;
  row_t   row_wdata;

  assign sel_set     = touch_valid ? touch_set : fill_set;
  assign sel_row     = rows[sel_set];
  assign lru_count_o = sel_row;
  assign init_busy   = (state == INIT);
  assign fill_ready  = (state == RUN) && !touch_valid;
  assign fill_accept = fill_valid && fill_ready;
  assign upd_way     = touch_valid ? touch_way : replace_way_i;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_next    = state;
    init_ptr_next = init_ptr;
    row_we        = 1'b0;
    row_waddr     = sel_set;
    row_wdata     = sel_row;
    case (state)
      INIT: begin
        row_we    = 1'b1;
        row_waddr = init_ptr;
        row_wdata = '0;
        if (init_ptr == set_t'(NUM_SETS - 1)) begin
          state_next    = RUN;
          init_ptr_next = '0;
        end else begin
          init_ptr_next = init_ptr + set_t'(1);
        end
      end
      RUN: begin
        if (touch_valid || fill_accept) begin
          row_we    = 1'b1;
          row_wdata = touch_update(sel_row, upd_way, max_lru_value_i, replace_way_i);
        end
        if (flush) state_next = INIT;
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state     <= INIT;
      init_ptr  <= '0;
      fill_done <= 1'b0;
      fill_way  <= '0;
    end else begin
      state     <= state_next;
      init_ptr  <= init_ptr_next;
      fill_done <= fill_accept;
      if (fill_accept) fill_way <= replace_way_i;
    end
  end

  // NOTE: the counter array has no reset; the INIT sweep clears it one row per cycle.
  always_ff @(posedge clk) begin
    if (row_we) rows[row_waddr] <= row_wdata;
  end

endmodule

// File: tb/tb_tlb_lru_state.sv
// Randomised scoreboard bench for tlb_lru_state with a behavioural counter model
// and a small stand-in for the neighbouring tlb_lru min/max logic.
module tb_tlb_lru_state;
  import tlb_lru_state_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, init_busy;
  logic        touch_valid, fill_valid, fill_ready, fill_done;
  logic [3:0]  touch_set, fill_set;
  logic [1:0]  touch_way, fill_way, replace_way_i;
  logic [15:0] lru_count_o;
  logic [3:0]  max_lru_value_i;

  int vectors     = 0;
  int miscompares = 0;
  int mdl [16][4];
  int exp_q [$];

  always #5 clk = ~clk;

  tlb_lru_state dut (
    .clk(clk), .rst(rst), .flush(flush), .init_busy(init_busy),
    .touch_valid(touch_valid), .touch_set(touch_set), .touch_way(touch_way),
    .fill_valid(fill_valid), .fill_set(fill_set), .fill_ready(fill_ready),
    .fill_done(fill_done), .fill_way(fill_way), .lru_count_o(lru_count_o),
    .replace_way_i(replace_way_i), .max_lru_value_i(max_lru_value_i)
  );

  // Stand-in for tlb_lru: lowest-index minimum way and maximum count of the row.
  logic [1:0] nb_way;
  logic [3:0] nb_min, nb_max;
  always_comb begin
    nb_way = 2'd0;
    nb_min = lru_count_o[3:0];
    nb_max = lru_count_o[3:0];
    for (int i = 1; i < 4; i++) begin
      if (lru_count_o[i*4 +: 4] < nb_min) begin
        nb_min = lru_count_o[i*4 +: 4];
        nb_way = 2'(i);
      end
      if (lru_count_o[i*4 +: 4] > nb_max) nb_max = lru_count_o[i*4 +: 4];
    end
    replace_way_i   = nb_way;
    max_lru_value_i = nb_max;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pack_row(input int s);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'(mdl[s][i]);
    return r;
  endfunction

  function automatic int model_victim(input int s);
    int v = 0;
    for (int i = 1; i < 4; i++) if (mdl[s][i] < mdl[s][v]) v = i;
    return v;
  endfunction

  task automatic model_touch(input int s, input int w);
    int mx = 0, mn = 15, nmax = 0;
    for (int i = 0; i < 4; i++) begin
      if (mdl[s][i] > mx) mx = mdl[s][i];
      if (mdl[s][i] < mn) mn = mdl[s][i];
    end
    for (int i = 0; i < 4; i++) if (mdl[s][i] == mx) nmax++;
    if (mdl[s][w] == mx && nmax == 1) return;
    if (mx < 15) begin
      mdl[s][w] = mx + 1;
    end else if (mn > 0) begin
      for (int i = 0; i < 4; i++) mdl[s][i] = mdl[s][i] - mn;
      mdl[s][w] = 16 - mn;
    end else begin
      for (int i = 0; i < 4; i++) mdl[s][i] = mdl[s][i] / 2;
      mdl[s][w] = 8;
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 16; s++) for (int i = 0; i < 4; i++) mdl[s][i] = 0;
  endtask

  // Entered and left at posedge+1; checks the selected row before the update.
  task automatic cycle_op(input bit tv, input int ts, input int tw, input bit fv, input int fs);
    int s;
    int v;
    touch_valid = tv; touch_set = 4'(ts); touch_way = 2'(tw);
    fill_valid  = fv; fill_set  = 4'(fs);
    @(negedge clk);
    s = tv ? ts : fs;
    check("sel_row", lru_count_o, pack_row(s));
    check("fill_ready", fill_ready, !tv);
    if (tv) begin
      model_touch(ts, tw);
    end else if (fv) begin
      v = model_victim(fs);
      exp_q.push_back(v);
      model_touch(fs, v);
    end
    @(posedge clk); #1;
    touch_valid = 1'b0;
    fill_valid  = 1'b0;
  endtask

  task automatic expect_row(input int s, input logic [15:0] exp, input string name);
    fill_set = 4'(s);
    @(negedge clk);
    check(name, lru_count_o, exp);
    @(posedge clk); #1;
  endtask

  task automatic sweep(input string name);
    for (int s = 0; s < 16; s++) expect_row(s, pack_row(s), name);
  endtask

  task automatic measure_init(input string name);
    int n = 0;
    bit ready_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!init_busy) break;
      n++;
      if (fill_ready) ready_seen = 1'b1;
    end
    check({name, "_busy_cycles"}, n, 16);
    check({name, "_fill_ready"}, ready_seen, 0);
    @(posedge clk); #1;
  endtask

  // fill_done must match a queued acceptance, carrying the predicted victim.
  always @(negedge clk) begin
    if (fill_done) begin
      if (exp_q.size() == 0) check("fill_done_spurious", fill_done, 0);
      else check("fill_way", fill_way, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    touch_valid = 1'b0; touch_set = '0; touch_way = '0;
    fill_valid = 1'b0; fill_set = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_init_busy", init_busy, 1);
    check("reset_fill_done", fill_done, 0);
    check("reset_fill_way", fill_way, 0);
    rst = 1'b0;
    measure_init("init");
    model_clear();
    sweep("init_row");

    // Two fills on an all-zero set: ties resolve to the lowest way.
    cycle_op(0, 0, 0, 1, 2);
    expect_row(2, 16'h0001, "fill1_row");
    cycle_op(0, 0, 0, 1, 2);
    expect_row(2, 16'h0021, "fill2_row");

    // Touch and fill together: touch wins, fill accepted on the next cycle.
    cycle_op(1, 5, 2, 1, 5);
    cycle_op(0, 0, 0, 1, 5);
    expect_row(5, 16'h0102, "collide_row");

    // Saturate set 7 with a zero way present, then force a halve.
    for (int i = 0; i < 15; i++) cycle_op(1, 7, i % 2, 0, 0);
    expect_row(7, 16'h00EF, "pre_halve_row");
    cycle_op(1, 7, 1, 0, 0);
    expect_row(7, 16'h0087, "halve_row");

    // Saturate set 8 with no zero way, then force a rebase.
    for (int i = 0; i < 15; i++) cycle_op(1, 8, i % 4, 0, 0);
    expect_row(8, 16'hCFED, "pre_rebase_row");
    cycle_op(1, 8, 0, 0, 0);
    expect_row(8, 16'h0324, "rebase_row");

    // Random mix on a few sets so saturation paths recur.
    for (int n = 0; n < 600; n++) begin
      int r  = int'($urandom_range(0, 9));
      int ts = int'($urandom_range(0, 3));
      int tw = int'($urandom_range(0, 3));
      int fs = int'($urandom_range(0, 3));
      if (r < 5)       cycle_op(1, ts, tw, 0, fs);
      else if (r < 8)  cycle_op(0, ts, tw, 1, fs);
      else if (r == 8) cycle_op(1, ts, tw, 1, fs);
      else             cycle_op(0, ts, tw, 0, fs);
    end
    sweep("random_row");

    // Flush with a fill accepted in the same cycle, then reset partway into INIT.
    flush = 1'b1;
    cycle_op(0, 0, 0, 1, 3);
    flush = 1'b0;
    check("flush_init_busy", init_busy, 1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    measure_init("reinit");
    sweep("reinit_row");

    check("pending_fills", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
